// File: rtl/flash_update_sequencer.sv
// flash_update_sequencer: unprotect, erase, program and restore one flash sector.
// Define FLASH_VERIFY_EN to add a readback compare after every programmed word.
module flash_update_sequencer #(
  parameter logic [15:0] POLL_LIMIT      = 16'd50000,
  parameter logic [19:0] ERASE_PAGE_NONE = 20'hFFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [2:0]  sector,
  input  logic [23:0] base_addr,
  input  logic [16:0] word_count,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        start_rdsr,
  output logic        start_rdcr,
  output logic        start_wrcr,
  output logic [31:0] wr_data_csr,
  input  logic [31:0] rd_data_csr,
  input  logic        done_csr,
  output logic        start_addr,
  output logic        start_wrdata,
  output logic        start_rddata,
  output logic [23:0] rw_addr_data,
  output logic [31:0] wr_data_data,
  input  logic [31:0] rd_data_data,
  input  logic        done_data
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_RD_CR,
    S_UNPROT,
    S_ERASE,
    S_POLL_E,
    S_LOAD_ADDR,
    S_WAIT_WORD,
    S_WRITE,
    S_POLL_W,
`ifdef FLASH_VERIFY_EN
    S_VER_ADDR,
    S_VER_RD,
`endif
    S_NEXT,
    S_PROTECT,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state, state_n;
  logic        issued, issued_n;
  logic [15:0] poll_cnt, poll_n;
  logic [16:0] idx, idx_n;
  logic [2:0]  sec_q, sec_n;
  logic [23:0] base_q, base_n;
  logic [16:0] cnt_q, cnt_n;
  logic [31:0] cr_shadow, cr_n;
  logic [31:0] word_q, word_n;
  logic        error_n;
  logic [2:0]  code_n;
  logic        rdsr_n, rdcr_n, wrcr_n;
  logic        addr_n, wrd_n, rdd_n;
  logic [31:0] csr_n, dat_n;
  logic [23:0] adr_n;
  logic [31:0] unprot_v, erase_v;
  logic        st_idle, poll_last;

`ifndef FLASH_VERIFY_EN
  logic unused_rd;
  assign unused_rd = ^rd_data_data;
`endif

  assign st_idle   = (rd_data_csr[1:0] == 2'b00);
  assign poll_last = ({1'b0, poll_cnt} + 17'd1) >= {1'b0, POLL_LIMIT};

  // Control-register images for the unprotect and erase writes
  always_comb begin
    unprot_v = cr_shadow;
    unprot_v[5'd22 + 5'(sec_q)] = 1'b0;
    unprot_v[22:20] = 3'd7;
    erase_v = unprot_v;
    erase_v[22:20] = sec_q;
    erase_v[19:0] = ERASE_PAGE_NONE;
  end

  // Next-state, op issue and bookkeeping for the update flow
  always_comb begin
    state_n  = state;
    issued_n = issued;
    poll_n   = poll_cnt;
    idx_n    = idx;
    sec_n    = sec_q;
    base_n   = base_q;
    cnt_n    = cnt_q;
    cr_n     = cr_shadow;
    word_n   = word_q;
    error_n  = error;
    code_n   = err_code;
    rdsr_n   = 1'b0;
    rdcr_n   = 1'b0;
    wrcr_n   = 1'b0;
    addr_n   = 1'b0;
    wrd_n    = 1'b0;
    rdd_n    = 1'b0;
    csr_n    = wr_data_csr;
    adr_n    = rw_addr_data;
    dat_n    = wr_data_data;
    unique case (state)
      S_IDLE: begin
        if (cmd_start) begin
          sec_n   = sector;
          base_n  = base_addr;
          cnt_n   = word_count;
          idx_n   = '0;
          error_n = 1'b0;
          code_n  = 3'd0;
          state_n = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sec_q >= 3'd1 && sec_q <= 3'd5) begin
          state_n = S_RD_CR;
        end else begin
          code_n  = 3'd5;
          state_n = S_ERR;
        end
      end
      S_RD_CR: begin
        if (!issued) begin
          rdcr_n   = 1'b1;
          issued_n = 1'b1;
        end else if (done_csr) begin
          cr_n    = rd_data_csr;
          state_n = S_UNPROT;
        end
      end
      S_UNPROT: begin
        if (!issued) begin
          wrcr_n   = 1'b1;
          csr_n    = unprot_v;
          issued_n = 1'b1;
        end else if (done_csr) begin
          state_n = S_ERASE;
        end
      end
      S_ERASE: begin
        if (!issued) begin
          wrcr_n   = 1'b1;
          csr_n    = erase_v;
          issued_n = 1'b1;
        end else if (done_csr) begin
          state_n = S_POLL_E;
        end
      end
      S_POLL_E: begin
        if (!issued) begin
          rdsr_n   = 1'b1;
          issued_n = 1'b1;
        end else if (done_csr) begin
          poll_n   = poll_cnt + 16'd1;
          issued_n = 1'b0;
          if (st_idle) begin
            if (!rd_data_csr[4]) begin
              code_n  = 3'd1;
              state_n = S_ERR;
            end else if (cnt_q == '0) begin
              state_n = S_PROTECT;
            end else begin
              state_n = S_LOAD_ADDR;
            end
          end else if (poll_last) begin
            code_n  = 3'd4;
            state_n = S_ERR;
          end
        end
      end
      S_LOAD_ADDR: begin
        if (!issued) begin
          addr_n   = 1'b1;
          adr_n    = base_q + 24'(idx);
          issued_n = 1'b1;
        end else if (done_data) begin
          state_n = S_WAIT_WORD;
        end
      end
      S_WAIT_WORD: begin
        if (in_valid && in_ready) begin
          word_n  = in_data;
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!issued) begin
          wrd_n    = 1'b1;
          dat_n    = word_q;
          issued_n = 1'b1;
        end else if (done_data) begin
          state_n = S_POLL_W;
        end
      end
      S_POLL_W: begin
        if (!issued) begin
          rdsr_n   = 1'b1;
          issued_n = 1'b1;
        end else if (done_csr) begin
          poll_n   = poll_cnt + 16'd1;
          issued_n = 1'b0;
          if (st_idle) begin
            if (!rd_data_csr[3]) begin
              code_n  = 3'd2;
              state_n = S_ERR;
            end else begin
`ifdef FLASH_VERIFY_EN
              state_n = S_VER_ADDR;
`else
              state_n = S_NEXT;
`endif
            end
          end else if (poll_last) begin
            code_n  = 3'd4;
            state_n = S_ERR;
          end
        end
      end
`ifdef FLASH_VERIFY_EN
      S_VER_ADDR: begin
        if (!issued) begin
          addr_n   = 1'b1;
          issued_n = 1'b1;
        end else if (done_data) begin
          state_n = S_VER_RD;
        end
      end
      S_VER_RD: begin
        if (!issued) begin
          rdd_n    = 1'b1;
          issued_n = 1'b1;
        end else if (done_data) begin
          if (rd_data_data != word_q) begin
            code_n  = 3'd3;
            state_n = S_ERR;
          end else begin
            state_n = S_NEXT;
          end
        end
      end
`endif
      S_NEXT: begin
        idx_n = idx + 17'd1;
        if (idx + 17'd1 == cnt_q) begin
          state_n = S_PROTECT;
        end else begin
          state_n = S_LOAD_ADDR;
        end
      end
      S_PROTECT: begin
        if (!issued) begin
          wrcr_n   = 1'b1;
          csr_n    = cr_shadow;
          issued_n = 1'b1;
        end else if (done_csr) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      S_ERR: begin
        error_n = 1'b1;
        state_n = (err_code == 3'd5) ? S_DONE : S_PROTECT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State and working registers; issue flag and poll count restart per state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      issued    <= 1'b0;
      poll_cnt  <= '0;
      idx       <= '0;
      sec_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      cr_shadow <= '0;
      word_q    <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      sec_q     <= sec_n;
      base_q    <= base_n;
      cnt_q     <= cnt_n;
      cr_shadow <= cr_n;
      word_q    <= word_n;
      if (state_n != state) begin
        issued   <= 1'b0;
        poll_cnt <= '0;
      end else begin
        issued   <= issued_n;
        poll_cnt <= poll_n;
      end
    end
  end

  // Registered outputs: op pulses, handshake and status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      in_ready     <= 1'b0;
      error        <= 1'b0;
      err_code     <= '0;
      start_rdsr   <= 1'b0;
      start_rdcr   <= 1'b0;
      start_wrcr   <= 1'b0;
      start_addr   <= 1'b0;
      start_wrdata <= 1'b0;
      start_rddata <= 1'b0;
      wr_data_csr  <= '0;
      rw_addr_data <= '0;
      wr_data_data <= '0;
    end else begin
      busy         <= (state_n != S_IDLE);
      done         <= (state_n == S_DONE);
      in_ready     <= (state_n == S_WAIT_WORD);
      error        <= error_n;
      err_code     <= code_n;
      start_rdsr   <= rdsr_n;
      start_rdcr   <= rdcr_n;
      start_wrcr   <= wrcr_n;
      start_addr   <= addr_n;
      start_wrdata <= wrd_n;
      start_rddata <= rdd_n;
      wr_data_csr  <= csr_n;
      rw_addr_data <= adr_n;
      wr_data_data <= dat_n;
    end
  end

endmodule

// File: tb/tb_flash_update_sequencer.sv
// tb_flash_update_sequencer: scoreboard bench with a flash responder model.
// Expected op streams come from a flow-level reference model.
module tb_flash_update_sequencer;

  localparam logic [15:0] LIM = 16'd8;
  localparam logic [2:0] K_RDCR = 3'd0;
  localparam logic [2:0] K_WRCR = 3'd1;
  localparam logic [2:0] K_RDSR = 3'd2;
  localparam logic [2:0] K_ADDR = 3'd3;
  localparam logic [2:0] K_WRD  = 3'd4;
  localparam logic [2:0] K_RDD  = 3'd5;
  localparam logic [2:0] K_DONE = 3'd6;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
  } op_t;

  logic        clk, reset, cmd_start;
  logic [2:0]  sector;
  logic [23:0] base_addr;
  logic [16:0] word_count;
  logic [31:0] in_data;
  logic        in_valid, in_ready, busy, done, error;
  logic [2:0]  err_code;
  logic        start_rdsr, start_rdcr, start_wrcr;
  logic [31:0] wr_data_csr, rd_data_csr;
  logic        done_csr;
  logic        start_addr, start_wrdata, start_rddata;
  logic [23:0] rw_addr_data;
  logic [31:0] wr_data_data, rd_data_data;
  logic        done_data;

  flash_update_sequencer #(.POLL_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start),
    .sector(sector), .base_addr(base_addr),
    .word_count(word_count), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .error(error),
    .err_code(err_code), .start_rdsr(start_rdsr),
    .start_rdcr(start_rdcr), .start_wrcr(start_wrcr),
    .wr_data_csr(wr_data_csr), .rd_data_csr(rd_data_csr),
    .done_csr(done_csr), .start_addr(start_addr),
    .start_wrdata(start_wrdata), .start_rddata(start_rddata),
    .rw_addr_data(rw_addr_data), .wr_data_data(wr_data_data),
    .rd_data_data(rd_data_data), .done_data(done_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  op_t         exp_q[$];
  logic [31:0] rsp_q[$];
  logic [31:0] rdb_q[$];
  logic [31:0] words[$];
  int          wi;

  int          s_sector, s_count, e_busy;
  logic [23:0] s_base;
  logic [31:0] s_cr, e_fin;
  int          w_busy[$];
  logic [31:0] w_fin[$];
  logic [31:0] w_rb[$];
  logic [2:0]  exp_code;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", nm, act, req);
    end
  endtask

  task automatic push_op(input logic [2:0] k, input logic [31:0] d);
    op_t o;
    o.kind = k;
    o.data = d;
    exp_q.push_back(o);
  endtask

  // One status-poll phase: nb busy reads, then the final status
  task automatic poll(input int nb, input logic [31:0] fin,
                      input int bitn, output int r);
    logic [31:0] bv;
    for (int i = 0; i < nb && i < int'(LIM); i++) begin
      bv = $urandom;
      bv[1:0] = 2'($urandom_range(1, 3));
      push_op(K_RDSR, 32'h0);
      rsp_q.push_back(bv);
    end
    if (nb >= int'(LIM)) begin
      r = 2;
    end else begin
      push_op(K_RDSR, 32'h0);
      rsp_q.push_back(fin);
      r = fin[bitn] ? 0 : 1;
    end
  endtask

  // Reference model of the whole update flow
  task automatic build();
    logic [31:0] unp, ers;
    logic [23:0] a;
    int r;
    logic [2:0] code;
    exp_q.delete();
    rsp_q.delete();
    rdb_q.delete();
    code = 3'd0;
    if (s_sector < 1 || s_sector > 5) begin
      exp_code = 3'd5;
      push_op(K_DONE, {28'd0, 1'b1, 3'd5});
      return;
    end
    push_op(K_RDCR, 32'h0);
    unp = s_cr;
    unp[22 + s_sector] = 1'b0;
    unp[22:20] = 3'd7;
    push_op(K_WRCR, unp);
    ers = unp;
    ers[22:20] = s_sector[2:0];
    ers[19:0] = 20'hFFFFF;
    push_op(K_WRCR, ers);
    poll(e_busy, e_fin, 4, r);
    if (r == 2) code = 3'd4;
    else if (r == 1) code = 3'd1;
    for (int i = 0; code == 3'd0 && i < s_count; i++) begin
      a = s_base + 24'(i);
      push_op(K_ADDR, {8'd0, a});
      push_op(K_WRD, words[i]);
      poll(w_busy[i], w_fin[i], 3, r);
      if (r == 2) code = 3'd4;
      else if (r == 1) code = 3'd2;
`ifdef FLASH_VERIFY_EN
      if (code == 3'd0) begin
        push_op(K_ADDR, {8'd0, a});
        push_op(K_RDD, 32'h0);
        rdb_q.push_back(w_rb[i]);
        if (w_rb[i] != words[i]) code = 3'd3;
      end
`endif
    end
    push_op(K_WRCR, s_cr);
    exp_code = code;
    push_op(K_DONE, {28'd0, code != 3'd0, code});
  endtask

  task automatic scen(input int sec, input logic [23:0] base, input int cnt);
    s_sector = sec;
    s_base = base;
    s_count = cnt;
    s_cr = $urandom;
    e_busy = 2;
    e_fin = 32'h18;
    words.delete();
    w_busy.delete();
    w_fin.delete();
    w_rb.delete();
    for (int i = 0; i < cnt; i++) begin
      words.push_back(32'hA0 + i);
      w_busy.push_back(1);
      w_fin.push_back(32'h18);
      w_rb.push_back(32'hA0 + i);
    end
  endtask

  task automatic scen_rand();
    int pick;
    logic [31:0] f;
    pick = $urandom_range(0, 9);
    if (pick < 8) s_sector = $urandom_range(1, 5);
    else if (pick == 8) s_sector = 0;
    else s_sector = $urandom_range(6, 7);
    scen(s_sector, 24'($urandom), $urandom_range(0, 5));
    e_busy = ($urandom_range(0, 19) == 0) ? int'(LIM) : $urandom_range(0, 3);
    f = $urandom;
    f[1:0] = 2'b00;
    f[4] = ($urandom_range(0, 9) != 0);
    e_fin = f;
    for (int i = 0; i < s_count; i++) begin
      words[i] = $urandom;
      w_rb[i] = ($urandom_range(0, 9) == 0) ? ~words[i] : words[i];
      w_busy[i] = ($urandom_range(0, 29) == 0) ? int'(LIM) : $urandom_range(0, 3);
      f = $urandom;
      f[1:0] = 2'b00;
      f[3] = ($urandom_range(0, 14) != 0);
      w_fin[i] = f;
    end
  endtask

  // Scoreboard compare of one observed DUT event
  task automatic obs(input logic [2:0] k, input logic [31:0] d);
    op_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL op_extra got kind=%0d data=%h required none", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.data != d) begin
        errors++;
        $display("FAIL op got kind=%0d data=%h required kind=%0d data=%h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  // Monitor: compare every op pulse and done against the queue
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (start_rdcr) obs(K_RDCR, 32'h0);
        if (start_wrcr) obs(K_WRCR, wr_data_csr);
        if (start_rdsr) obs(K_RDSR, 32'h0);
        if (start_addr) obs(K_ADDR, {8'd0, rw_addr_data});
        if (start_wrdata) obs(K_WRD, wr_data_data);
        if (start_rddata) obs(K_RDD, 32'h0);
        if (done) obs(K_DONE, {28'd0, error, err_code});
      end
    end
  end

  // Flash wrapper responder: random latency, one op outstanding
  initial begin
    int pend, ns;
    logic pcsr;
    logic [31:0] pdat;
    pend = 0;
    pcsr = 1'b0;
    pdat = '0;
    done_csr = 1'b0;
    done_data = 1'b0;
    rd_data_csr = '0;
    rd_data_data = '0;
    forever begin
      @(negedge clk);
      done_csr = 1'b0;
      done_data = 1'b0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            if (pcsr) begin
              done_csr = 1'b1;
              rd_data_csr = pdat;
            end else begin
              done_data = 1'b1;
              rd_data_data = pdat;
            end
          end
        end
        ns = int'(start_rdsr) + int'(start_rdcr) + int'(start_wrcr)
           + int'(start_addr) + int'(start_wrdata) + int'(start_rddata);
        if (ns > 0) begin
          checks++;
          if (pend != 0 || ns != 1 || done_csr || done_data) begin
            errors++;
            $display("FAIL one_outstanding got starts=%0d pending=%0d required 1 and 0",
                     ns, pend);
          end
          pend = $urandom_range(1, 3);
          pcsr = start_rdsr | start_rdcr | start_wrcr;
          pdat = 32'h0;
          if (start_rdcr) pdat = s_cr;
          if (start_rdsr) begin
            if (rsp_q.size() > 0) pdat = rsp_q.pop_front();
            else pdat = 32'h1;
          end
          if (start_rddata && rdb_q.size() > 0) pdat = rdb_q.pop_front();
        end
      end
    end
  end

  // Word-stream source with random in_valid gaps
  initial begin
    logic xfer;
    xfer = 1'b0;
    wi = 0;
    in_valid = 1'b0;
    in_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        xfer = 1'b0;
        in_valid = 1'b0;
      end else begin
        if (xfer) begin
          wi++;
          chk("ready_drop", {31'd0, in_ready}, 32'd0);
        end
        in_valid = (wi < words.size()) && ($urandom_range(0, 3) != 0);
        in_data = (wi < words.size()) ? words[wi] : 32'h0;
        xfer = in_valid && in_ready;
      end
    end
  end

  task automatic outs_zero(input string nm);
    chk({nm, "_ctl"}, {19'd0, busy, done, error, err_code, start_rdsr,
        start_rdcr, start_wrcr, start_addr, start_wrdata, start_rddata,
        in_ready}, 32'd0);
    chk({nm, "_dat"}, wr_data_csr | wr_data_data | {8'd0, rw_addr_data},
        32'd0);
  endtask

  task automatic flush();
    exp_q.delete();
    rsp_q.delete();
    rdb_q.delete();
    words.delete();
  endtask

  task automatic start_cmd();
    build();
    wi = 0;
    @(negedge clk);
    sector = 3'(s_sector);
    base_addr = s_base;
    word_count = 17'(s_count);
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_rise", {31'd0, busy}, 32'd1);
  endtask

  task automatic finish_cmd(input string nm);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout got no done required done", nm);
      reset = 1'b1;
      @(negedge clk);
      flush();
      @(negedge clk);
      reset = 1'b0;
    end else begin
      chk({nm, "_busy_at_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({nm, "_busy_fall"}, {31'd0, busy}, 32'd0);
      chk({nm, "_drain"}, exp_q.size(), 32'd0);
      chk({nm, "_err_hold"}, {28'd0, error, err_code},
          {28'd0, exp_code != 3'd0, exp_code});
    end
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cmd_start = 1'b0;
    sector = '0;
    base_addr = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    outs_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    scen(3, 24'h010000, 4);
    s_cr = 32'h02AB_CDEF;
    start_cmd();
    finish_cmd("normal");

    scen(6, 24'h000100, 2);
    start_cmd();
    finish_cmd("sector6");
    scen(0, 24'h000100, 2);
    start_cmd();
    finish_cmd("sector0");
    scen(7, 24'h000100, 1);
    start_cmd();
    finish_cmd("sector7");

    scen(1, 24'h000200, 3);
    e_fin = 32'h0000_0000;
    start_cmd();
    finish_cmd("erase_fail");

    scen(4, 24'h000300, 3);
    e_busy = int'(LIM);
    start_cmd();
    finish_cmd("poll_timeout");

    scen(2, 24'h000400, 4);
    w_fin[2] = 32'h10;
    start_cmd();
    finish_cmd("write_fail");

    scen(5, 24'h000500, 3);
    w_busy[1] = int'(LIM);
    start_cmd();
    finish_cmd("write_timeout");

    scen(2, 24'h123456, 0);
    start_cmd();
    finish_cmd("zero_words");

    scen(5, 24'hFFFFFE, 4);
    start_cmd();
    finish_cmd("addr_wrap");

`ifdef FLASH_VERIFY_EN
    scen(3, 24'h000600, 2);
    words[0] = 32'h1234_5678;
    w_rb[0] = 32'hDEAD_BEEF;
    start_cmd();
    finish_cmd("verify_mismatch");
`endif

    scen(3, 24'h000700, 3);
    start_cmd();
    n = 0;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_wait_word", {31'd0, in_ready}, 32'd1);
    #2 reset = 1'b1;
    #1 outs_zero("reset_mid");
    flush();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    scen(3, 24'h000800, 3);
    start_cmd();
    finish_cmd("after_reset");

    for (int t = 0; t < 14; t++) begin
      scen_rand();
      start_cmd();
      finish_cmd("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
